// File: rtl/sram_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic SRAM port between requesters A and B.
// Grant lasts one bus cycle; a watchdog aborts cycles that never see an ack.
module sram_wb_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        a_cyc_i,
  input  logic        a_we_i,
  input  logic [3:0]  a_sel_i,
  input  logic [9:0]  a_addr_i,
  input  logic [31:0] a_dat_i,
  output logic        a_ack_o,
  output logic        a_err_o,
  output logic [31:0] a_dat_o,

  input  logic        b_cyc_i,
  input  logic        b_we_i,
  input  logic [3:0]  b_sel_i,
  input  logic [9:0]  b_addr_i,
  input  logic [31:0] b_dat_i,
  output logic        b_ack_o,
  output logic        b_err_o,
  output logic [31:0] b_dat_o,

  output logic        sram_cyc_o,
  output logic        sram_stb_o,
  output logic        sram_we_o,
  output logic [3:0]  sram_sel_o,
  output logic [9:0]  sram_addr_o,
  output logic [31:0] sram_dat_o,
  input  logic [31:0] sram_dat_i,
  input  logic        sram_ack_i,

  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            last_b_q, last_b_d;
  logic [TO_W-1:0] wd_q, wd_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    wd_d        = wd_q;
    a_ack_o     = 1'b0;
    a_err_o     = 1'b0;
    a_dat_o     = 32'h0;
    b_ack_o     = 1'b0;
    b_err_o     = 1'b0;
    b_dat_o     = 32'h0;
    sram_cyc_o  = 1'b0;
    sram_we_o   = 1'b0;
    sram_sel_o  = 4'h0;
    sram_addr_o = 10'h0;
    sram_dat_o  = 32'h0;
    grant_o     = 2'b00;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        // On a tie, the port that was not served last wins.
        if (a_cyc_i && (!b_cyc_i || last_b_q)) begin
          state_d = GNT_A;
        end else if (b_cyc_i) begin
          state_d = GNT_B;
        end
      end

      GNT_A: begin
        grant_o     = 2'b01;
        sram_cyc_o  = a_cyc_i;
        sram_we_o   = a_we_i;
        sram_sel_o  = a_sel_i;
        sram_addr_o = a_addr_i;
        sram_dat_o  = a_dat_i;
        if (!a_cyc_i) begin
          state_d  = IDLE;
          last_b_d = 1'b0;
        end else if (sram_ack_i) begin
          a_ack_o  = 1'b1;
          a_dat_o  = sram_dat_i;
          state_d  = IDLE;
          last_b_d = 1'b0;
        end else if (wd_q == WD_LAST) begin
          a_err_o  = 1'b1;
          state_d  = IDLE;
          last_b_d = 1'b0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      GNT_B: begin
        grant_o     = 2'b10;
        sram_cyc_o  = b_cyc_i;
        sram_we_o   = b_we_i;
        sram_sel_o  = b_sel_i;
        sram_addr_o = b_addr_i;
        sram_dat_o  = b_dat_i;
        if (!b_cyc_i) begin
          state_d  = IDLE;
          last_b_d = 1'b1;
        end else if (sram_ack_i) begin
          b_ack_o  = 1'b1;
          b_dat_o  = sram_dat_i;
          state_d  = IDLE;
          last_b_d = 1'b1;
        end else if (wd_q == WD_LAST) begin
          b_err_o  = 1'b1;
          state_d  = IDLE;
          last_b_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // A cycle killed by reset must not report completion to its requester.
    if (reset) begin
      a_ack_o = 1'b0;
      a_err_o = 1'b0;
      a_dat_o = 32'h0;
      b_ack_o = 1'b0;
      b_err_o = 1'b0;
      b_dat_o = 32'h0;
    end
  end

  assign sram_stb_o = sram_cyc_o;

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Directed scenarios followed by random traffic, every cycle checked against a transaction-level model.
module tb_sram_wb_arbiter;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_cyc_i, a_we_i, b_cyc_i, b_we_i;
  logic [3:0]  a_sel_i, b_sel_i;
  logic [9:0]  a_addr_i, b_addr_i;
  logic [31:0] a_dat_i, b_dat_i;
  logic        a_ack_o, a_err_o, b_ack_o, b_err_o;
  logic [31:0] a_dat_o, b_dat_o;
  logic        sram_cyc_o, sram_stb_o, sram_we_o;
  logic [3:0]  sram_sel_o;
  logic [9:0]  sram_addr_o;
  logic [31:0] sram_dat_o, sram_dat_i;
  logic        sram_ack_i;
  logic [1:0]  grant_o;

  always #5 clock = ~clock;

  sram_wb_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clock(clock), .reset(reset),
    .a_cyc_i(a_cyc_i), .a_we_i(a_we_i), .a_sel_i(a_sel_i), .a_addr_i(a_addr_i), .a_dat_i(a_dat_i),
    .a_ack_o(a_ack_o), .a_err_o(a_err_o), .a_dat_o(a_dat_o),
    .b_cyc_i(b_cyc_i), .b_we_i(b_we_i), .b_sel_i(b_sel_i), .b_addr_i(b_addr_i), .b_dat_i(b_dat_i),
    .b_ack_o(b_ack_o), .b_err_o(b_err_o), .b_dat_o(b_dat_o),
    .sram_cyc_o(sram_cyc_o), .sram_stb_o(sram_stb_o), .sram_we_o(sram_we_o),
    .sram_sel_o(sram_sel_o), .sram_addr_o(sram_addr_o), .sram_dat_o(sram_dat_o),
    .sram_dat_i(sram_dat_i), .sram_ack_i(sram_ack_i), .grant_o(grant_o)
  );

  int total = 0;
  int bad   = 0;

  // Model: owner of the bus (0 none, 1 A, 2 B), last owner served, granted cycles so far.
  int m_gnt  = 0;
  int m_last = 2;
  int m_held = 0;

  logic        e_a_ack = 1'b0, e_a_err = 1'b0, e_b_ack = 1'b0, e_b_err = 1'b0;
  logic        o_a_ack, o_a_err, o_b_ack, o_b_err, o_cyc;
  logic [31:0] o_a_dat;
  logic [1:0]  o_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [118:0] exp_v, obs_v;
    logic         cyc, ack, err, we;
    logic [3:0]   sel;
    logic [9:0]   addr;
    logic [31:0]  wdat;
    logic [1:0]   gnt;
    @(negedge clock);
    cyc  = (m_gnt == 1 && a_cyc_i) || (m_gnt == 2 && b_cyc_i);
    ack  = cyc && sram_ack_i && !reset;
    err  = cyc && !sram_ack_i && (m_held == TIMEOUT) && !reset;
    we   = (m_gnt == 1) ? a_we_i   : (m_gnt == 2) ? b_we_i   : 1'b0;
    sel  = (m_gnt == 1) ? a_sel_i  : (m_gnt == 2) ? b_sel_i  : 4'h0;
    addr = (m_gnt == 1) ? a_addr_i : (m_gnt == 2) ? b_addr_i : 10'h0;
    wdat = (m_gnt == 1) ? a_dat_i  : (m_gnt == 2) ? b_dat_i  : 32'h0;
    gnt  = (m_gnt == 1) ? 2'b01 : (m_gnt == 2) ? 2'b10 : 2'b00;
    e_a_ack = ack && (m_gnt == 1);
    e_a_err = err && (m_gnt == 1);
    e_b_ack = ack && (m_gnt == 2);
    e_b_err = err && (m_gnt == 2);
    exp_v = {cyc, cyc, we, sel, addr, wdat,
             e_a_ack, e_a_err, (e_a_ack ? sram_dat_i : 32'h0),
             e_b_ack, e_b_err, (e_b_ack ? sram_dat_i : 32'h0), gnt};
    obs_v = {sram_cyc_o, sram_stb_o, sram_we_o, sram_sel_o, sram_addr_o, sram_dat_o,
             a_ack_o, a_err_o, a_dat_o, b_ack_o, b_err_o, b_dat_o, grant_o};
    o_a_ack = a_ack_o; o_a_err = a_err_o; o_a_dat = a_dat_o;
    o_b_ack = b_ack_o; o_b_err = b_err_o; o_grant = grant_o; o_cyc = sram_cyc_o;
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL cycle_outputs t=%0t observed=%h expected=%h", $time, obs_v, exp_v);
    end
    if (reset) begin
      m_gnt = 0; m_last = 2; m_held = 0;
    end else if (m_gnt == 0) begin
      if (a_cyc_i && b_cyc_i) m_gnt = (m_last == 1) ? 2 : 1;
      else if (a_cyc_i)       m_gnt = 1;
      else if (b_cyc_i)       m_gnt = 2;
      m_held = 1;
    end else if (!cyc || ack || err) begin
      m_last = m_gnt;
      m_gnt  = 0;
    end else begin
      m_held++;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin : main
    int n;
    logic saw_ack;
    logic [1:0] gseq [6];
    int divs [4];
    int div, a_act, b_act;
    gseq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    divs = '{1, 2, 3, 24};

    reset = 1'b1;
    a_cyc_i = 0; a_we_i = 0; a_sel_i = 0; a_addr_i = 0; a_dat_i = 0;
    b_cyc_i = 0; b_we_i = 0; b_sel_i = 0; b_addr_i = 0; b_dat_i = 0;
    sram_ack_i = 0; sram_dat_i = 0;
    @(posedge clock); #1;
    step();
    chk("reset_grant", 32'(o_grant), 32'h0);
    chk("reset_cyc", 32'(o_cyc), 32'h0);
    reset = 1'b0;

    // Single A read, ack on second granted cycle
    a_cyc_i = 1; a_we_i = 0; a_sel_i = 4'hF; a_addr_i = 10'h155;
    step();
    chk("t1_cyc_before_grant", 32'(o_cyc), 32'h0);
    step();
    chk("t1_cyc_rise", 32'(o_cyc), 32'h1);
    chk("t1_grant_a", 32'(o_grant), 32'h1);
    sram_ack_i = 1; sram_dat_i = 32'hDEADBEEF;
    step();
    chk("t1_ack", 32'(o_a_ack), 32'h1);
    chk("t1_rdata", o_a_dat, 32'hDEADBEEF);
    a_cyc_i = 0; sram_ack_i = 0;
    step();
    chk("t1_grant_idle", 32'(o_grant), 32'h0);

    // Both ports requesting continuously after reset
    reset = 1; step(); reset = 0;
    a_cyc_i = 1; b_cyc_i = 1; sram_ack_i = 1; sram_dat_i = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t2_grant_%0d", i), 32'(o_grant), 32'(gseq[i]));
      if (gseq[i] == 2'b01) chk("t2_no_b_ack_in_a", 32'(o_b_ack), 32'h0);
    end

    // B write with no ack times out; A waits then gets the bus
    a_cyc_i = 0; b_cyc_i = 0; sram_ack_i = 0;
    step();
    b_cyc_i = 1; b_we_i = 1; b_sel_i = 4'b0100; b_addr_i = 10'h0F0; b_dat_i = 32'h00AA0000;
    step();
    a_cyc_i = 1;
    n = 0; saw_ack = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (o_b_ack) saw_ack = 1;
      if (o_b_err) break;
    end
    chk("t3_err_after_cycles", 32'(n), 32'd16);
    chk("t3_no_b_ack", 32'(saw_ack), 32'h0);
    b_cyc_i = 0;
    step();
    step();
    chk("t3_a_granted_next", 32'(o_grant), 32'h1);
    sram_ack_i = 1;
    step();
    a_cyc_i = 0; sram_ack_i = 0;
    step();

    // Ack on the last watchdog cycle beats the timeout
    a_cyc_i = 1;
    step();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    sram_ack_i = 1;
    step();
    chk("t4_ack_wins", 32'(o_a_ack), 32'h1);
    chk("t4_no_err", 32'(o_a_err), 32'h0);
    a_cyc_i = 0; sram_ack_i = 0;
    step();

    // Requester abandons the cycle while an ack arrives
    a_cyc_i = 1;
    step();
    for (int i = 0; i < 3; i++) step();
    a_cyc_i = 0; sram_ack_i = 1;
    step();
    chk("t5_cyc_dropped", 32'(o_cyc), 32'h0);
    chk("t5_ack_discarded", 32'(o_a_ack), 32'h0);
    sram_ack_i = 0;
    step();
    chk("t5_idle_next", 32'(o_grant), 32'h0);

    // Reset in the middle of a B grant
    b_cyc_i = 1;
    step();
    step();
    chk("t6_grant_b", 32'(o_grant), 32'h2);
    a_cyc_i = 1; reset = 1; sram_ack_i = 1;
    step();
    chk("t6_no_b_ack", 32'(o_b_ack), 32'h0);
    chk("t6_no_b_err", 32'(o_b_err), 32'h0);
    reset = 0; sram_ack_i = 0;
    step();
    chk("t6_idle_after_reset", 32'(o_grant), 32'h0);
    step();
    chk("t6_a_first", 32'(o_grant), 32'h1);
    a_cyc_i = 0; b_cyc_i = 0;
    step();
    step();

    // Random traffic
    a_act = 0; b_act = 0; div = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) div = divs[(c / 500) % 4];
      reset = ($urandom_range(0, 299) == 0);
      if (a_act != 0 && (e_a_ack || e_a_err)) begin
        a_act = 0; a_cyc_i = 0;
      end else if (a_act == 0 && $urandom_range(0, 3) == 0) begin
        a_act = 1; a_cyc_i = 1; a_we_i = 1'($urandom); a_sel_i = 4'($urandom);
        a_addr_i = 10'($urandom); a_dat_i = $urandom;
      end else if (a_act != 0 && $urandom_range(0, 49) == 0) begin
        a_act = 0; a_cyc_i = 0;
      end
      if (b_act != 0 && (e_b_ack || e_b_err)) begin
        b_act = 0; b_cyc_i = 0;
      end else if (b_act == 0 && $urandom_range(0, 3) == 0) begin
        b_act = 1; b_cyc_i = 1; b_we_i = 1'($urandom); b_sel_i = 4'($urandom);
        b_addr_i = 10'($urandom); b_dat_i = $urandom;
      end else if (b_act != 0 && $urandom_range(0, 49) == 0) begin
        b_act = 0; b_cyc_i = 0;
      end
      sram_ack_i = ($urandom_range(0, div - 1) == 0);
      sram_dat_i = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
